// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the common data bus (CDB).
//   - arb_state_e : bus-owner FSM states
//   - CDB_TAG_W / CDB_NO_RS : RS tag width and the "no station" tag
//   - ADD_RS1..3 : adder reservation-station tags (shared with the RS blocks)
//   - HOLD_W : width of the grant hold counter (HOLD_CYCLES up to 15)
package cdb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam int CDB_TAG_W = 6;
  localparam logic [CDB_TAG_W-1:0] CDB_NO_RS = 6'b000000;

  localparam logic [CDB_TAG_W-1:0] ADD_RS1 = 6'd1;
  localparam logic [CDB_TAG_W-1:0] ADD_RS2 = 6'd2;
  localparam logic [CDB_TAG_W-1:0] ADD_RS3 = 6'd3;

  localparam int HOLD_W = 4;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req    [NUM_UNITS-1:0] : request vector
//   rr_ptr [ID_W-1:0]      : highest-priority index (must be < NUM_UNITS)
//   valid                  : any request present
//   winner [ID_W-1:0]      : first set bit scanning up from rr_ptr, wrapping
//   onehot [NUM_UNITS-1:0] : winner as one-hot (all zero when !valid)
module rr_picker #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 valid,
  output logic [ID_W-1:0]      winner,
  output logic [NUM_UNITS-1:0] onehot
);

  logic [2*NUM_UNITS-1:0] req2;
  logic [2*NUM_UNITS-1:0] rot;
  logic [ID_W-1:0]        off;
  logic [ID_W:0]          sum;

  // Rotate the doubled vector so bit 0 is rr_ptr, find the first set offset,
  // then map the offset back to an absolute unit index modulo NUM_UNITS.
  always_comb begin
    req2  = {req, req};
    rot   = req2 >> rr_ptr;
    valid = |req;
    off   = '0;
    for (int j = NUM_UNITS-1; j >= 0; j--) begin
      if (rot[j]) off = ID_W'(j);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_UNITS)) sum = sum - (ID_W+1)'(NUM_UNITS);
    winner = sum[ID_W-1:0];
    onehot = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      onehot[i] = valid && (winner == ID_W'(i));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: bus-owner side of the CDB handshake. Grants one functional
// unit at a time (round-robin) for HOLD_CYCLES cycles, then releases the bus
// for one turnaround cycle, and flags broadcast protocol violations.
//   clock, reset_n (async, active low)
//   CDB_rts    in  : request-to-send per unit
//   CDB_xmit   out : registered one-hot grant per unit
//   CDB_write  in  : bus write strobe seen on the shared CDB
//   CDB_source in  : RS tag currently on the CDB (monitored only)
//   bus_busy   out : high while a grant is active
//   grant_id   out : granted unit index, 0 when idle
//   protocol_error out : one-cycle registered violation pulse
// Optional statistics (macro CDB_ARB_STATS_EN): grant_count[15:0],
// busy_cycles[31:0], err_count[7:0], all saturating, cleared on reset.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int ID_W        = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] CDB_rts,
  output logic [NUM_UNITS-1:0] CDB_xmit,
  input  logic                 CDB_write,
  input  logic [CDB_TAG_W-1:0] CDB_source,
  output logic                 bus_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 protocol_error
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [15:0]          grant_count,
  output logic [31:0]          busy_cycles,
  output logic [7:0]           err_count
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES-1);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NUM_UNITS-1:0] xmit_q, xmit_d;
  logic [NUM_UNITS-1:0] last_q, last_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;
  logic                 perr_q, perr_d;

  logic [NUM_UNITS-1:0] pick_req;
  logic [NUM_UNITS-1:0] pick_oh;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_vld;
  logic                 in_grant;

  // The RELEASE cycle is the only turnaround cycle: the unit just released
  // is masked out there (it may still be clearing rts), and any other
  // requester is granted on the edge that leaves RELEASE, so back-to-back
  // grants start HOLD_CYCLES+1 cycles apart.
  assign pick_req = (state_q == ARB_RELEASE) ? (CDB_rts & ~last_q) : CDB_rts;
  assign in_grant = (state_q == ARB_GRANT);

  rr_picker #(
    .NUM_UNITS(NUM_UNITS),
    .ID_W     (ID_W)
  ) u_pick (
    .req   (pick_req),
    .rr_ptr(rr_ptr_q),
    .valid (pick_vld),
    .winner(pick_id),
    .onehot(pick_oh)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    xmit_d     = xmit_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;

    // Violations: silent full-length grant, write without grant, null tag.
    perr_d = (in_grant && (hold_cnt_q == '0) && !CDB_write) ||
             (!in_grant && CDB_write) ||
             (in_grant && CDB_write && (CDB_source == CDB_NO_RS));

    case (state_q)
      ARB_IDLE, ARB_RELEASE: begin
        if (pick_vld) begin
          state_d    = ARB_GRANT;
          xmit_d     = pick_oh;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        // Full window done, or the owner withdrew its request early.
        if ((hold_cnt_q == '0) || !(|(CDB_rts & xmit_q))) begin
          state_d    = ARB_RELEASE;
          last_d     = xmit_q;
          xmit_d     = '0;
          busy_d     = 1'b0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          rr_ptr_d   = (grant_id_q == ID_W'(NUM_UNITS-1)) ? '0 : grant_id_q + ID_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        xmit_d     = '0;
        busy_d     = 1'b0;
        grant_id_d = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      xmit_q     <= '0;
      last_q     <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      xmit_q     <= xmit_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
    end
  end

  assign CDB_xmit       = xmit_q;
  assign bus_busy       = busy_q;
  assign grant_id       = grant_id_q;
  assign protocol_error = perr_q;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] gcnt_q, gcnt_d;
  logic [31:0] bcyc_q, bcyc_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic        grant_evt;

  assign grant_evt = (state_d == ARB_GRANT) && (state_q != ARB_GRANT);

  always_comb begin
    gcnt_d = gcnt_q;
    bcyc_d = bcyc_q;
    ecnt_d = ecnt_q;
    if (grant_evt && (gcnt_q != '1)) gcnt_d = gcnt_q + 16'd1;
    if (busy_q    && (bcyc_q != '1)) bcyc_d = bcyc_q + 32'd1;
    if (perr_q    && (ecnt_q != '1)) ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gcnt_q <= '0;
      bcyc_q <= '0;
      ecnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      bcyc_q <= bcyc_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign grant_count = gcnt_q;
  assign busy_cycles = bcyc_q;
  assign err_count   = ecnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (NUM_UNITS=4, HOLD_CYCLES=2).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N   = 4;
  localparam int H   = 2;
  localparam int IDW = 3;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N-1:0]         CDB_rts = '0;
  logic [N-1:0]         CDB_xmit;
  logic                 CDB_write = 1'b0;
  logic [CDB_TAG_W-1:0] CDB_source = '0;
  logic                 bus_busy;
  logic [IDW-1:0]       grant_id;
  logic                 protocol_error;
`ifdef CDB_ARB_STATS_EN
  logic [15:0]          grant_count;
  logic [31:0]          busy_cycles;
  logic [7:0]           err_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_x;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_UNITS(N), .HOLD_CYCLES(H), .ID_W(IDW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .CDB_rts       (CDB_rts),
    .CDB_xmit      (CDB_xmit),
    .CDB_write     (CDB_write),
    .CDB_source    (CDB_source),
    .bus_busy      (bus_busy),
    .grant_id      (grant_id),
    .protocol_error(protocol_error)
`ifdef CDB_ARB_STATS_EN
    ,
    .grant_count   (grant_count),
    .busy_cycles   (busy_cycles),
    .err_count     (err_count)
`endif
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state, before any clock edge and after edges held in reset
    #1;
    chk("rst_xmit", CDB_xmit, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_perr", protocol_error, 0);
    CDB_rts = 4'b1111;
    tick; tick;
    chk("rst_hold_xmit", CDB_xmit, 0);
    chk("rst_hold_busy", bus_busy, 0);
    CDB_rts = '0;
    reset_n = 1'b1;

    // single request from unit 2
    CDB_rts = 4'b0100;
    tick;
    chk("s_xmit0", CDB_xmit, 4'b0100);
    chk("s_gid", grant_id, 2);
    chk("s_busy", bus_busy, 1);
    chk("s_perr0", protocol_error, 0);
    CDB_write = 1'b1; CDB_source = ADD_RS1;
    tick;
    chk("s_xmit1", CDB_xmit, 4'b0100);
    chk("s_perr1", protocol_error, 0);
    tick;
    chk("s_rel_xmit", CDB_xmit, 0);
    chk("s_rel_busy", bus_busy, 0);
    chk("s_rel_gid", grant_id, 0);
    chk("s_rel_perr", protocol_error, 0);
    CDB_write = 1'b0; CDB_rts = '0;
    tick;
    chk("s_idle_xmit", CDB_xmit, 0);
    chk("s_idle_perr", protocol_error, 0);

    // unit never broadcasts (rr_ptr=3 -> unit 0 wins)
    CDB_rts = 4'b0001;
    tick;
    chk("nw_xmit", CDB_xmit, 4'b0001);
    chk("nw_gid", grant_id, 0);
    tick;
    chk("nw_perr_mid", protocol_error, 0);
    tick;
    chk("nw_perr_last", protocol_error, 1);
    chk("nw_rel_xmit", CDB_xmit, 0);
    CDB_rts = '0;
    tick;
    chk("nw_perr_clr", protocol_error, 0);
    // write without grant in IDLE
    CDB_write = 1'b1;
    tick;
    chk("iw_perr", protocol_error, 1);
    chk("iw_xmit", CDB_xmit, 0);
    CDB_write = 1'b0;
    tick;
    chk("iw_perr_clr", protocol_error, 0);

    // null tag broadcast (rr_ptr=1 -> unit 1)
    CDB_rts = 4'b0010;
    tick;
    chk("nt_xmit", CDB_xmit, 4'b0010);
    CDB_write = 1'b1; CDB_source = CDB_NO_RS;
    tick;
    chk("nt_perr", protocol_error, 1);
    chk("nt_xmit1", CDB_xmit, 4'b0010);
    CDB_source = ADD_RS2;
    tick;
    chk("nt_perr_clr", protocol_error, 0);
    chk("nt_rel_xmit", CDB_xmit, 0);
    CDB_write = 1'b0; CDB_rts = '0;
    tick;

    // asynchronous reset in the middle of a grant (rr_ptr=2 -> unit 3)
    CDB_rts = 4'b1000;
    tick;
    chk("ar_xmit", CDB_xmit, 4'b1000);
    chk("ar_gid", grant_id, 3);
    CDB_write = 1'b1; CDB_source = ADD_RS3;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_async_xmit", CDB_xmit, 0);
    chk("ar_async_busy", bus_busy, 0);
    chk("ar_async_gid", grant_id, 0);
    CDB_write = 1'b0;
    CDB_rts = 4'b1010;
    #2 reset_n = 1'b1;
    tick;
    chk("ar_first_xmit", CDB_xmit, 4'b0010);
    chk("ar_first_gid", grant_id, 1);
    CDB_write = 1'b1; CDB_source = ADD_RS1;
    tick; tick;
    chk("ar_rel_xmit", CDB_xmit, 0);
    CDB_write = 1'b0; CDB_rts = '0;
    tick;

    // all units requesting: rotation 0,1,2,3,0 with 2 high / 1 low
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    CDB_source = ADD_RS1;
    CDB_rts = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick;
      exp_x = ((i % 3) < 2) ? (4'b0001 << ((i / 3) % 4)) : 4'b0000;
      chk($sformatf("rr_xmit%0d", i), CDB_xmit, exp_x);
      chk($sformatf("rr_busy%0d", i), bus_busy, ((i % 3) < 2) ? 1 : 0);
      chk($sformatf("rr_perr%0d", i), protocol_error, 0);
      CDB_write = |CDB_xmit;
    end

    // early release: unit 0 drops rts after one cycle
    CDB_rts = 4'b1110;
    tick;
    chk("er0_xmit", CDB_xmit, 0);
    chk("er0_perr", protocol_error, 0);
    CDB_write = 1'b0;
    tick;
    chk("er1_xmit", CDB_xmit, 4'b0010);
    chk("er1_gid", grant_id, 1);
    // unit 1 drops after one cycle; units 0 and 2 request
    CDB_rts = 4'b0101; CDB_write = 1'b1; CDB_source = ADD_RS2;
    tick;
    chk("er1_rel_xmit", CDB_xmit, 0);
    chk("er1_rel_busy", bus_busy, 0);
    chk("er1_rel_perr", protocol_error, 0);
    CDB_write = 1'b0;
    tick;
    chk("er2_xmit", CDB_xmit, 4'b0100);
    chk("er2_gid", grant_id, 2);
    CDB_write = 1'b1; CDB_source = ADD_RS3;
    tick; tick;
    chk("er2_rel_xmit", CDB_xmit, 0);
    chk("er2_rel_perr", protocol_error, 0);
    CDB_write = 1'b0; CDB_rts = '0;
    tick;
    chk("er2_idle_perr", protocol_error, 0);

`ifdef CDB_ARB_STATS_EN
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("st_rst_gc", grant_count, 0);
    chk("st_rst_bc", busy_cycles, 0);
    for (int g = 0; g < 5; g++) begin
      CDB_rts = 4'b0001; CDB_write = 1'b0;
      tick;
      CDB_write = 1'b1; CDB_source = ADD_RS1;
      tick; tick;
      CDB_rts = '0; CDB_write = 1'b0;
      tick;
    end
    chk("st_gc", grant_count, 5);
    chk("st_bc", busy_cycles, 10);
    chk("st_ec0", err_count, 0);
    CDB_write = 1'b1;
    repeat (300) tick;
    CDB_write = 1'b0;
    tick;
    chk("st_ec_sat", err_count, 255);
    chk("st_bc_keep", busy_cycles, 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
